keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameter SCAN_DIV, 16'h7000, HCLK cycles per column slot (range 4..65535).
REQ-002 SHALL provide parameter DEBOUNCE_CNT, 4, consecutive matching samples required to accept a press or a release (range 1..15).
Ports (name, direction, width, meaning):
REQ-003 SHALL provide HCLK  in  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide HRESET  in  1  asynchronous active-high reset.
REQ-005 SHALL provide row_in  in  4  keypad row lines, active-low, externally pulled up, asynchronous to HCLK.
REQ-006 SHALL provide col_out  out  4  column drive, one-hot-low.
REQ-007 SHALL provide key_valid  out  1  key event pending; level signal, held until acknowledged.
REQ-008 SHALL provide key_code  out  4  event code, row*4 + col.
REQ-009 SHALL provide key_ack  in  1  one-cycle pulse that consumes the pending event.
REQ-010 SHALL provide key_down  out  1  high while a debounced key is held.
REQ-011 SHALL provide overrun  out  1  sticky flag; set when an event is dropped.

Function
REQ-012 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-013 SHALL run a slot counter 0..SCAN_DIV-1 and sample rs on the cycle where the count equals SCAN_DIV-1.
REQ-014 SHALL, in state SCAN, rotate col_out 1110->1101->1011->0111->1110 at each sample where no row is low.
REQ-015 SHALL, in SCAN, on a sample with any rs bit low, latch col index c and the lowest low row index r, freeze col_out, and go to DEBOUNCE with cnt=1.
REQ-016 SHALL, in DEBOUNCE, increment cnt at each sample where rs[r] is still low; at cnt==DEBOUNCE_CNT it SHALL publish the event and go to HOLD.
REQ-017 SHALL, in DEBOUNCE, on a sample with rs[r] high, return to SCAN and advance col_out to the next column.
REQ-018 SHALL, with DEBOUNCE_CNT=1, publish on the first detecting sample.
REQ-019 SHALL, in HOLD, keep col_out frozen and assert key_down; a release is counted at each sample with rs[r] high, and any low sample resets the count to 0.
REQ-020 SHALL, in HOLD, when the release count reaches DEBOUNCE_CNT, deassert key_down, return to SCAN, and advance the column.
REQ-021 SHALL publish an event as follows: if key_valid==0, or key_ack is high in the same cycle, set key_valid=1 and key_code={r,c} on the next edge.
REQ-022 SHALL, when publishing while key_valid==1 without key_ack, keep the old key_code, drop the new event, and set overrun.
REQ-023 SHALL, on key_ack with no simultaneous publish, clear key_valid and overrun on the next edge; key_ack while key_valid==0 SHALL be ignored.
REQ-024 SHALL hold key_code stable while key_valid==1, except in the REQ-021 ack+publish case.
REQ-025 SHALL never detect a second key while in DEBOUNCE or HOLD (no rollover).

Reset
REQ-026 SHALL, on HRESET, put: state=SCAN, col_out=1110, slot counter=0, cnt=0, synchronizer=1111, key_valid=0, key_code=0, key_down=0, overrun=0.
REQ-027 SHALL, on reset asserted mid-debounce or mid-hold, discard the pending key; after release, scanning restarts at column 0.

Configuration
REQ-028 SHALL, when KEYPAD_RELEASE_EVENT_EN is defined, add output key_release (1 bit), published like an event at REQ-020 with key_code={r,c}, key_release=1, and the same valid/ack/overrun rules; press events SHALL carry key_release=0.
REQ-029 SHALL, without KEYPAD_RELEASE_EVENT_EN, omit the key_release port and generate no release events.

Verification
REQ-030 SHALL cover the basic press: SCAN_DIV=8, DEBOUNCE_CNT=4, row 2 low while col 1 driven -> key_valid rises 3 samples after detect, key_code=4'h9, key_down=1.
REQ-031 SHALL cover bounce: row low for 2 samples then high -> no key_valid, col_out resumes rotating from 1011.
REQ-032 SHALL cover overrun: two distinct presses with no ack -> key_code keeps the first code, overrun=1; key_ack -> key_valid=0, overrun=0.
REQ-033 SHALL cover ack+publish in the same cycle -> key_valid stays 1, key_code = new code, overrun=0.
REQ-034 SHALL cover reset in HOLD: HRESET pulse during HOLD -> all outputs at reset values, col_out=1110.
REQ-035 SHALL cover the release path with KEYPAD_RELEASE_EVENT_EN defined: press then release of key 4'h0 -> two events, key_release 0 then 1.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and a single-entry
// event register (key_valid / key_code / key_ack, sticky overrun).
//
// Columns are driven one-hot-low and rotate once per column slot while no
// key is seen. A detected key locks the column, is debounced, reported once,
// and then held until a debounced release brings the scanner back.
// Only one key is tracked at a time; other keys are ignored until release.
//
// Optional feature (define to enable):
//   KEYPAD_RELEASE_EVENT_EN - adds output key_release and reports debounced
//                             releases as events (key_release=1); press events
//                             carry key_release=0.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_SCAN     | rotating columns, looking for any low row at each sample
// S_DEBOUNCE | column frozen, counting consecutive low samples of the row
// S_HOLD     | key accepted, key_down high, counting high samples to release

module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 16'h7000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
`ifdef KEYPAD_RELEASE_EVENT_EN
    ,
    output logic       key_release
`endif
);

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_LAST   = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    // synchronizer and slot timing
    logic [3:0]  r_sync_meta;
    logic [3:0]  r_sync;
    logic [15:0] r_slot;
    logic        w_sample;

    // scan state
    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_col;
    logic [1:0]  w_col_nxt;
    logic [1:0]  r_row;
    logic [1:0]  w_row_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_inc;

    // row decode of the synchronized sample
    logic        w_any_low;
    logic [1:0]  w_low_row;
    logic        w_key_low;

    // event publishing
    logic        w_pub;
    logic        w_pub_press;
    logic [3:0]  w_pub_code;
    logic        r_valid;
    logic [3:0]  r_code;
    logic        r_overrun;
`ifdef KEYPAD_RELEASE_EVENT_EN
    logic        w_pub_release;
    logic        r_release;
`endif

    // Two-flop synchronizer; idle (released) value is all ones.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sync_meta <= 4'hF;
            r_sync      <= 4'hF;
        end else begin
            r_sync_meta <= row_in;
            r_sync      <= r_sync_meta;
        end
    end

    // Column slot counter; the last count of each slot is the sample point.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_slot <= '0;
        end else if (r_slot == SLOT_LAST) begin
            r_slot <= '0;
        end else begin
            r_slot <= r_slot + 16'd1;
        end
    end

    assign w_sample = (r_slot == SLOT_LAST);

    // Lowest-numbered low row wins when several rows are low at once.
    always_comb begin
        w_low_row = 2'd0;
        w_any_low = (r_sync != 4'hF);
        for (int i = 3; i >= 0; i--) begin
            if (!r_sync[i]) begin
                w_low_row = 2'(i);
            end
        end
    end

    assign w_key_low = ~r_sync[r_row];
    assign w_cnt_inc = r_cnt + 4'd1;

    // Scanner state, locked column/row and debounce counter.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_SCAN;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; everything moves only on sample cycles.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_cnt_nxt     = r_cnt;
        w_pub_press   = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
        w_pub_release = 1'b0;
`endif
        case (r_state)
            S_SCAN: begin
                if (w_sample) begin
                    if (w_any_low) begin
                        w_row_nxt = w_low_row;
                        if (DB_LAST == 4'd1) begin
                            w_pub_press = 1'b1;
                            w_state_nxt = S_HOLD;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                            w_cnt_nxt   = 4'd1;
                        end
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_sample) begin
                    if (w_key_low) begin
                        if (w_cnt_inc == DB_LAST) begin
                            w_pub_press = 1'b1;
                            w_state_nxt = S_HOLD;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        // bounce: give up on this key and move on
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = r_col + 2'd1;
                        w_cnt_nxt   = 4'd0;
                    end
                end
            end
            S_HOLD: begin
                if (w_sample) begin
                    if (!w_key_low) begin
                        if (w_cnt_inc == DB_LAST) begin
`ifdef KEYPAD_RELEASE_EVENT_EN
                            w_pub_release = 1'b1;
`endif
                            w_state_nxt = S_SCAN;
                            w_col_nxt   = r_col + 2'd1;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_SCAN;
                w_col_nxt   = 2'd0;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

`ifdef KEYPAD_RELEASE_EVENT_EN
    assign w_pub = w_pub_press | w_pub_release;
`else
    assign w_pub = w_pub_press;
`endif

    // Row comes from the next-row value so a first-sample publish sees the new row.
    assign w_pub_code = {w_row_nxt, r_col};

    // Single-entry event register: ack frees the slot, a publish into a full
    // slot is dropped and flagged as overrun.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_valid   <= 1'b0;
            r_code    <= 4'd0;
            r_overrun <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
            r_release <= 1'b0;
`endif
        end else if (w_pub) begin
            if (!r_valid || key_ack) begin
                r_valid   <= 1'b1;
                r_code    <= w_pub_code;
`ifdef KEYPAD_RELEASE_EVENT_EN
                r_release <= w_pub_release;
`endif
                if (key_ack) begin
                    r_overrun <= 1'b0;
                end
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (key_ack && r_valid) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign col_out   = ~(4'b0001 << r_col);
    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign key_down  = (r_state == S_HOLD);
    assign overrun   = r_overrun;
`ifdef KEYPAD_RELEASE_EVENT_EN
    assign key_release = r_release;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan: keypad matrix model driving row_in from col_out,
// a sample-level behavioural reference of scan/debounce/event rules, directed
// scenarios followed by randomized key activity and random acks.
// Honors KEYPAD_RELEASE_EVENT_EN when defined.

module tb_keypad_scan;

    localparam int SD = 8;
    localparam int DB = 4;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ack;
    logic       key_down;
    logic       overrun;
    logic       w_rel;
`ifdef KEYPAD_RELEASE_EVENT_EN
    logic       key_release;
    assign w_rel = key_release;
`else
    assign w_rel = 1'b0;
`endif

    keypad_scan #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DB)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
`ifdef KEYPAD_RELEASE_EVENT_EN
        ,
        .key_release (key_release)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // pressed keys, bit index = row*4 + col
    logic [15:0] keys;

    // keypad matrix: a row is pulled low by any pressed key in a driven column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    int n_tests;
    int n_fail;
    int n_edge;
    bit g_rand_ack;

    // reference model state
    int         m_col;
    int         m_lock;
    logic       m_held;
    int         m_run;
    int         m_rel;
    bit         m_last_sample;
    logic       m_v;
    logic [3:0] m_code;
    logic       m_ov;
    logic       m_relf;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_col  = 0;
        m_lock = -1;
        m_held = 1'b0;
        m_run  = 0;
        m_rel  = 0;
        m_v    = 1'b0;
        m_code = 4'd0;
        m_ov   = 1'b0;
        m_relf = 1'b0;
        m_last_sample = 1'b0;
    endtask

    function automatic int lowest_row(input logic [3:0] low);
        for (int r = 0; r < 4; r++) begin
            if (low[r]) return r;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs held over that edge.
    task automatic model_edge();
        bit         pub;
        logic [3:0] pcode;
        bit         prel;
        logic [3:0] low;
        pub   = 1'b0;
        pcode = 4'd0;
        prel  = 1'b0;
        m_last_sample = ((n_edge % SD) == SD - 1);
        if (m_last_sample) begin
            if (m_lock < 0) begin
                for (int r = 0; r < 4; r++) low[r] = keys[r*4 + m_col];
                if (low != 4'd0) begin
                    m_lock = lowest_row(low) * 4 + m_col;
                    m_run  = 1;
                    if (m_run == DB) begin
                        pub = 1'b1; pcode = 4'(m_lock); m_held = 1'b1; m_rel = 0;
                    end
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (!m_held) begin
                if (keys[m_lock]) begin
                    m_run++;
                    if (m_run == DB) begin
                        pub = 1'b1; pcode = 4'(m_lock); m_held = 1'b1; m_rel = 0;
                    end
                end else begin
                    m_lock = -1;
                    m_col  = (m_col + 1) % 4;
                end
            end else begin
                if (!keys[m_lock]) begin
                    m_rel++;
                    if (m_rel == DB) begin
`ifdef KEYPAD_RELEASE_EVENT_EN
                        pub = 1'b1; pcode = 4'(m_lock); prel = 1'b1;
`endif
                        m_held = 1'b0;
                        m_lock = -1;
                        m_col  = (m_col + 1) % 4;
                    end
                end else begin
                    m_rel = 0;
                end
            end
        end
        if (pub) begin
            if (!m_v || key_ack) begin
                m_v = 1'b1; m_code = pcode; m_relf = prel;
                if (key_ack) m_ov = 1'b0;
            end else begin
                m_ov = 1'b1;
            end
        end else if (key_ack && m_v) begin
            m_v  = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [3:0] ec;
        ec = 4'hF;
        ec[m_col] = 1'b0;
        return {4'b0, ec, m_held, m_v, m_code, m_ov, m_relf};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {4'b0, col_out, key_down, key_valid, key_code, overrun, w_rel};
    endfunction

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic step();
        if (g_rand_ack) key_ack = ($urandom_range(0, 11) == 0);
        @(posedge HCLK);
        #1;
        model_edge();
        check_val("outputs", obs_vec(), exp_vec());
        n_edge++;
        if (g_rand_ack) key_ack = 1'b0;
        if (n_fail > 40) finish_run();
    endtask

    task automatic advance_to_sample();
        for (int i = 0; i < SD; i++) begin
            step();
            if (m_last_sample) break;
        end
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
    endtask

    task automatic apply_reset();
        HRESET  = 1'b1;
        key_ack = 1'b0;
        #1;
        check_val("rst_col",   col_out,   4'hE);
        check_val("rst_valid", key_valid, 1'b0);
        check_val("rst_code",  key_code,  4'h0);
        check_val("rst_down",  key_down,  1'b0);
        check_val("rst_ovr",   overrun,   1'b0);
        check_val("rst_rel",   w_rel,     1'b0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_reset();
        n_edge = 0;
    endtask

    task automatic wait_down(input logic level, input string tag);
        for (int i = 0; i < 60 * SD && key_down != level; i++) step();
        check_val(tag, key_down, level);
    endtask

    task automatic press_release(input int key);
        advance_to_sample();
        keys = 16'(1) << key;
        wait_down(1'b1, "pr_down");
        advance_to_sample();
        keys = 16'd0;
        wait_down(1'b0, "pr_up");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ap_done;
        int hold_left;
        int sel;
        n_tests    = 0;
        n_fail     = 0;
        n_edge     = 0;
        g_rand_ack = 1'b0;
        keys       = 16'd0;
        key_ack    = 1'b0;
        HRESET     = 1'b1;
        model_reset();

        apply_reset();

        // basic press: row 2 on column 1
        keys = 16'h0200;
        for (int i = 0; i < 60 * SD && !key_valid; i++) step();
        check_val("press_valid", key_valid, 1'b1);
        check_val("press_code",  key_code,  4'h9);
        check_val("press_down",  key_down,  1'b1);
        advance_to_sample();
        keys = 16'd0;
        wait_down(1'b0, "press_up");
        check_val("press_code_kept", key_code, 4'h9);
        ack_pulse();
        check_val("ack_valid", key_valid, 1'b0);
        check_val("ack_ovr",   overrun,   1'b0);
        ack_pulse();
        check_val("idle_ack", key_valid, 1'b0);

        // bounce: two low samples, then high
        for (int i = 0; i < 8; i++) begin
            advance_to_sample();
            if (col_out == 4'b1101) break;
        end
        check_val("bounce_start", col_out, 4'b1101);
        keys = 16'h0200;
        advance_to_sample();
        advance_to_sample();
        keys = 16'd0;
        advance_to_sample();
        check_val("bounce_col",   col_out,   4'b1011);
        check_val("bounce_valid", key_valid, 1'b0);
        advance_to_sample();
        check_val("bounce_rot",   col_out,   4'b0111);

        // overrun: two presses without ack
        press_release(6);
        press_release(13);
        check_val("ovr_valid", key_valid, 1'b1);
        check_val("ovr_code",  key_code,  4'h6);
        check_val("ovr_flag",  overrun,   1'b1);

        // ack coincident with a press publish
        advance_to_sample();
        keys = 16'h0008;
        ap_done = 1'b0;
        for (int i = 0; i < 60 * SD && !ap_done; i++) begin
            if (((n_edge % SD) == SD - 1) && m_lock >= 0 && !m_held && m_run == DB - 1 && keys[m_lock]) begin
                ack_pulse();
                ap_done = 1'b1;
            end else begin
                step();
            end
        end
        check_val("ap_found", ap_done,   1'b1);
        check_val("ap_valid", key_valid, 1'b1);
        check_val("ap_code",  key_code,  4'h3);
        check_val("ap_ovr",   overrun,   1'b0);
        advance_to_sample();
        keys = 16'd0;
        wait_down(1'b0, "ap_up");
        press_release(12);
        check_val("ovr2_flag", overrun, 1'b1);
        ack_pulse();
        check_val("ovr2_valid", key_valid, 1'b0);
        check_val("ovr2_clr",   overrun,   1'b0);

        // reset while holding a key
        advance_to_sample();
        keys = 16'h0020;
        wait_down(1'b1, "hold_down");
        keys = 16'd0;
        apply_reset();
        for (int i = 0; i < 3 * SD; i++) step();

`ifdef KEYPAD_RELEASE_EVENT_EN
        // press and release of key 0 produce two events
        keys = 16'h0001;
        for (int i = 0; i < 60 * SD && !key_valid; i++) step();
        check_val("rp_code", key_code, 4'h0);
        check_val("rp_rel",  w_rel,    1'b0);
        check_val("rp_down", key_down, 1'b1);
        ack_pulse();
        advance_to_sample();
        keys = 16'd0;
        for (int i = 0; i < 60 * SD && !key_valid; i++) step();
        check_val("rr_valid", key_valid, 1'b1);
        check_val("rr_code",  key_code,  4'h0);
        check_val("rr_rel",   w_rel,     1'b1);
        check_val("rr_down",  key_down,  1'b0);
        ack_pulse();
`endif

        // randomized key activity with random acks
        g_rand_ack = 1'b1;
        hold_left  = 0;
        for (int s = 0; s < 300; s++) begin
            advance_to_sample();
            if (hold_left == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 4) keys = 16'd0;
                else if (sel < 8) keys = 16'(1) << $urandom_range(0, 15);
                else keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                hold_left = $urandom_range(1, 9);
            end else begin
                hold_left--;
            end
        end
        g_rand_ack = 1'b0;

        finish_run();
    end

endmodule
